tpu_sequencer: RTL and testbench



---
 rtl/tpu_pkg.sv | 20 ++
 rtl/tpu_sequencer_if.sv | 32 +++
 rtl/tpu_sequencer_delay.sv | 25 ++
 rtl/tpu_sequencer.sv | 122 ++++++++++++
 tb/tb_tpu_sequencer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default timing constants for the TPU pass sequencer.
package tpu_pkg;

    // Sequencer states; encodings are fixed so they can be matched in traces.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        POP_W  = 3'd2,
        RELOAD = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Cycles from an address issue to the matching result row.
    localparam int RESULT_LATENCY_DEF = 24;
    // Cycles the weight-reload strobe is held for one tile.
    localparam int WLOAD_CYCLES_DEF   = 8;

endpackage

// File: rtl/tpu_sequencer_if.sv
// Host / datapath signal bundle of the TPU pass sequencer.
interface tpu_sequencer_if #(
    parameter int ADDRESSSIZE = 10,
    parameter int MATRIX_SIZE = 8
);
    logic                           start;
    logic [ADDRESSSIZE-1:0]         base_addr;
    logic [$clog2(MATRIX_SIZE):0]   num_rows;
    logic                           fifo_empty;
    logic                           fifo_read_enable;
    logic                           we_rl;
    logic [ADDRESSSIZE-1:0]         ub_addr;
    logic                           ub_addr_valid;
    logic                           result_valid;
    logic [$clog2(MATRIX_SIZE)-1:0] result_index;
    logic                           busy;
    logic                           end_;

    // Host side: issues passes and reports FIFO state.
    modport master (
        output start, base_addr, num_rows, fifo_empty,
        input  fifo_read_enable, we_rl, ub_addr, ub_addr_valid,
               result_valid, result_index, busy, end_
    );

    // Sequencer side.
    modport slave (
        input  start, base_addr, num_rows, fifo_empty,
        output fifo_read_enable, we_rl, ub_addr, ub_addr_valid,
               result_valid, result_index, busy, end_
    );
endinterface

// File: rtl/tpu_sequencer_delay.sv
// Fixed-depth 1-bit delay line tracking which cycles carry live result rows.
module valid_delay_line #(
    parameter int DEPTH = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);
    logic [DEPTH-1:0] r_taps;

    // Shift the issue-valid flag one stage per cycle; reset flushes all in-flight rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps <= '0;
        end else begin
            r_taps[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) begin
                r_taps[k] <= r_taps[k-1];
            end
        end
    end

    assign o_dout = r_taps[DEPTH-1];
endmodule

// File: rtl/tpu_sequencer.sv
// Control FSM for one matrix-multiply pass: weight pop, reload, activation
// streaming and result-row tracking. All outputs are registered.
import tpu_pkg::*;

module tpu_sequencer #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 8,
    parameter int WLOAD_CYCLES   = WLOAD_CYCLES_DEF,
    parameter int RESULT_LATENCY = RESULT_LATENCY_DEF
) (
    input logic            clk,
    input logic            rst,
    tpu_sequencer_if.slave bus
);
    localparam int RW = $clog2(MATRIX_SIZE) + 1;
    localparam int IW = $clog2(MATRIX_SIZE);
    localparam int WW = $clog2(WLOAD_CYCLES + 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDRESSSIZE-1:0] r_addr;
    logic [ADDRESSSIZE-1:0] r_ub_addr;
    logic [RW-1:0]          r_rows;
    logic [RW-1:0]          r_issue;
    logic [RW-1:0]          r_res_cnt;
    logic [WW-1:0]          r_wl_cnt;
    logic [IW-1:0]          r_res_idx;
    logic                   r_fre;
    logic                   r_we_rl;
    logic                   r_ub_valid;
    logic                   r_busy;
    logic                   r_end;
    logic                   w_result_valid;

    valid_delay_line #(.DEPTH(RESULT_LATENCY)) u_valid_delay (
        .clk    (clk),
        .rst    (rst),
        .i_din  (r_ub_valid),
        .o_dout (w_result_valid)
    );

    // Next-state decode; DRAIN exits on the cycle the last result row appears.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (bus.start) w_state_next = (bus.num_rows == '0) ? DONE : WAIT_W;
            WAIT_W: if (!bus.fifo_empty) w_state_next = POP_W;
            POP_W:  w_state_next = RELOAD;
            RELOAD: if (r_wl_cnt == WW'(WLOAD_CYCLES - 1)) w_state_next = STREAM;
            STREAM: if (r_issue == r_rows) w_state_next = DRAIN;
            DRAIN:  if ((r_res_cnt == r_rows) ||
                        (w_result_valid && ((r_res_cnt + RW'(1)) == r_rows)))
                        w_state_next = DONE;
            DONE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, counters and registered outputs, all driven from the decoded next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_ub_addr  <= '0;
            r_rows     <= '0;
            r_issue    <= '0;
            r_res_cnt  <= '0;
            r_wl_cnt   <= '0;
            r_res_idx  <= '0;
            r_fre      <= 1'b0;
            r_we_rl    <= 1'b0;
            r_ub_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fre   <= (w_state_next == POP_W);
            r_we_rl <= (w_state_next == RELOAD);
            r_busy  <= (w_state_next != IDLE);
            r_end   <= (w_state_next == DONE);

            if (r_state == POP_W)
                r_wl_cnt <= '0;
            else if (r_state == RELOAD)
                r_wl_cnt <= r_wl_cnt + WW'(1);

            // Issue one activation address per STREAM cycle; wraps naturally.
            if (w_state_next == STREAM) begin
                r_ub_addr  <= r_addr;
                r_addr     <= r_addr + ADDRESSSIZE'(1);
                r_issue    <= r_issue + RW'(1);
                r_ub_valid <= 1'b1;
            end else begin
                r_ub_valid <= 1'b0;
            end

            // Result index advances after each valid row and holds otherwise.
            if (w_result_valid) begin
                r_res_cnt <= r_res_cnt + RW'(1);
                r_res_idx <= r_res_idx + IW'(1);
            end

            // Accepted start captures the pass parameters and restarts all counts.
            if (r_state == IDLE && bus.start) begin
                r_addr    <= bus.base_addr;
                r_rows    <= bus.num_rows;
                r_issue   <= '0;
                r_res_cnt <= '0;
                r_res_idx <= '0;
            end
        end
    end

    assign bus.fifo_read_enable = r_fre;
    assign bus.we_rl            = r_we_rl;
    assign bus.ub_addr          = r_ub_addr;
    assign bus.ub_addr_valid    = r_ub_valid;
    assign bus.result_valid     = w_result_valid;
    assign bus.result_index     = r_res_idx;
    assign bus.busy             = r_busy;
    assign bus.end_             = r_end;
endmodule

// File: tb/tb_tpu_sequencer.sv
// Randomized pass-level bench for tpu_sequencer with a cycle-timeline reference model.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    localparam int AW = 10;
    localparam int MS = 8;
    localparam int W  = WLOAD_CYCLES_DEF;
    localparam int L  = RESULT_LATENCY_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_sequencer_if #(.ADDRESSSIZE(AW), .MATRIX_SIZE(MS)) bus ();

    tpu_sequencer #(
        .ADDRESSSIZE    (AW),
        .MATRIX_SIZE    (MS),
        .WLOAD_CYCLES   (W),
        .RESULT_LATENCY (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pass_no = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s pass=%0d cyc=%0d got=%0h exp=%0h", tag, pass_no, cyc, got, exp);
        end
    endtask

    // One pass. Cycle k is the k-th negedge after start is driven (start sampled at edge 0).
    // e: cycles fifo_empty stays high after start; noise: stray start / fifo_empty toggles;
    // abort_at: cycle in which rst is driven high (0 = no abort).
    task automatic run_pass(input int base, input int rows, input int e,
                            input bit noise, input int abort_at);
        int s, end_c, t_len;
        bit ab, x_fre, x_we, x_v, x_rv, x_end, x_busy;
        int n_addr;
        n_addr = 0;
        s      = e + 3 + W;
        end_c  = (rows == 0) ? 1 : s + L + rows;
        t_len  = (abort_at > 0) ? s + L + rows + 3 : end_c + 1 + $urandom_range(0, 2);
        pass_no++;

        bus.start      = 1'b1;
        bus.base_addr  = base[AW-1:0];
        bus.num_rows   = rows[3:0];
        bus.fifo_empty = (e > 0);

        for (int k = 1; k <= t_len; k++) begin
            @(negedge clk);
            cyc    = k;
            ab     = (abort_at > 0) && (k > abort_at);
            x_fre  = !ab && rows > 0 && k == e + 2;
            x_we   = !ab && rows > 0 && k >= e + 3 && k <= e + 2 + W;
            x_v    = !ab && rows > 0 && k >= s && k < s + rows;
            x_rv   = !ab && rows > 0 && k >= s + L && k < s + L + rows;
            x_end  = !ab && k == end_c;
            x_busy = !ab && k <= end_c;

            check_eq("fifo_read_enable", int'(bus.fifo_read_enable), int'(x_fre));
            check_eq("we_rl",            int'(bus.we_rl),            int'(x_we));
            check_eq("ub_addr_valid",    int'(bus.ub_addr_valid),    int'(x_v));
            check_eq("result_valid",     int'(bus.result_valid),     int'(x_rv));
            check_eq("end_",             int'(bus.end_),             int'(x_end));
            check_eq("busy",             int'(bus.busy),             int'(x_busy));
            if (x_v) begin
                check_eq("ub_addr", int'(bus.ub_addr), (base + k - s) & ((1 << AW) - 1));
                n_addr++;
            end
            if (x_rv)
                check_eq("result_index", int'(bus.result_index), k - s - L);
            if (ab) begin
                check_eq("ub_addr_rst",      int'(bus.ub_addr),      0);
                check_eq("result_index_rst", int'(bus.result_index), 0);
            end

            // Drive inputs for this cycle (sampled at the following edge).
            bus.start = noise && (k <= end_c) && ($urandom_range(0, 3) == 0);
            if (bus.start) begin
                bus.base_addr = AW'($urandom);
                bus.num_rows  = 4'($urandom_range(0, MS));
            end
            if (k <= e)
                bus.fifo_empty = 1'b1;
            else if (k >= e + 2 && noise)
                bus.fifo_empty = 1'($urandom_range(0, 1));
            else
                bus.fifo_empty = 1'b0;
            rst = (abort_at > 0) && (k == abort_at);
        end
        bus.start = 1'b0;
        $display("[TB] pass %0d base=%03h rows=%0d empty_cycles=%0d noise=%0d abort_at=%0d addrs=%0d",
                 pass_no, base, rows, e, noise, abort_at, n_addr);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_rows   = '0;
        bus.fifo_empty = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",      int'(bus.busy),             0);
        check_eq("rst_fre",       int'(bus.fifo_read_enable), 0);
        check_eq("rst_we_rl",     int'(bus.we_rl),            0);
        check_eq("rst_ub_valid",  int'(bus.ub_addr_valid),    0);
        check_eq("rst_ub_addr",   int'(bus.ub_addr),          0);
        check_eq("rst_res_valid", int'(bus.result_valid),     0);
        check_eq("rst_res_index", int'(bus.result_index),     0);
        check_eq("rst_end",       int'(bus.end_),             0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: nominal, wrap-around, empty FIFO, zero rows, noisy, abort + recovery.
        run_pass(32'h010, 8, 0, 1'b0, 0);
        run_pass(32'h3FE, 4, 0, 1'b0, 0);
        run_pass(32'h123, 5, 5, 1'b0, 0);
        run_pass(32'h0AA, 0, 0, 1'b0, 0);
        run_pass(32'h200, 6, 2, 1'b1, 0);
        run_pass(32'h050, 8, 0, 1'b0, 3 + W + 2);
        run_pass(32'h051, 3, 1, 1'b0, 0);

        // Randomized passes.
        for (int i = 0; i < 24; i++) begin
            run_pass(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, MS)),
                     int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
